sd_spi_master: RTL
==================

// Module: sd_spi_master
// PURPOSE
//  CPU-mapped SPI master for SD card and other serial peripherals; successor to the fixed-mode SD port.
//  Adds programmable SCK divider, CPOL/CPHA mode, up to 4 chip selects, busy/overrun status, edge-qualified writes.
//  Sits on the CPU bus beside the memory decoder; one register window at BASE_ADDR..BASE_ADDR+3.
// PARAMETERS
//  BASE_ADDR   16'hF000  base of 4-byte register window (BASE_ADDR[1:0] must be 0)
//  NUM_CS      1         number of chip-select outputs, 1..4
//  DIV_RESET   8'd0      reset value of DIV register
// PORTS
//  c_sclk      in   1        system clock; all logic on posedge
//  reset       in   1        asynchronous, active-high reset
//  cpu_ADDR    in   16       CPU address, synchronous to c_sclk
//  o_cpu_data  in   8        CPU write data
//  cpu_nWR     in   1        CPU write strobe, active-low, may be held low many clocks
//  sd_o        out  8        read data mux for addressed register (0x00 outside window)
//  sd_sel      out  1        1 when cpu_ADDR within window (combinational)
//  busy        out  1        transfer in progress
//  SD_DAT      in   1        MISO
//  SD_CMD      out  1        MOSI
//  SD_CLK      out  1        SCK (registered, glitch-free)
//  SD_CS_N     out  NUM_CS   chip selects, active-low
// BEHAVIOUR
//  Write accept: cycle where cpu_nWR==0 and its previous-cycle sample ==1; one action per strobe.
//  Registers (offset): 0 DATA  W: start transfer of byte; R: last received byte.
//   1 CONF  W/R: [3:0] CS enable (bit n=1 drives SD_CS_N[n]=0, bits >=NUM_CS read 0), [4] CPOL, [5] CPHA.
//   2 DIV   W/R: SCK half period = DIV+1 clocks (8-bit, DIV=255 -> 256 clocks).
//   3 STAT  R: [0] busy, [1] OVR sticky; W: any value clears OVR.
//  Reset values: DATA(rx)=8'hFF, CONF=0, DIV=DIV_RESET, OVR=0, busy=0, SD_CLK=0, SD_CMD=1, SD_CS_N all 1.
//  FSM IDLE -> SHIFT -> IDLE.
//   IDLE: SD_CLK=CPOL, SD_CMD=1. Accepted DATA write: load tx shift reg, go SHIFT next cycle.
//   SHIFT: busy=1; 16 half-periods, MSB first; half-period counter reloads DIV each phase.
//    CPHA=0: bit7 on SD_CMD in first SHIFT cycle; sample SD_DAT on leading edge, shift MOSI on trailing.
//    CPHA=1: shift MOSI on leading edge, sample SD_DAT on trailing edge.
//   After 16th half-period: rx reg <= 8 sampled bits, busy=0, SD_CLK=CPOL, SD_CMD=1, back to IDLE (same cycle).
//  Latency: busy rises 1 clock after accepted write; busy high exactly 16*(DIV+1) clocks.
//  Writes to DATA, CONF or DIV while busy: ignored, OVR<=1. STAT write always clears OVR.
//  CONF CPOL change in IDLE: SD_CLK follows next clock. CS lines only change via CONF write (never auto).
//  rx reg holds value until next transfer completes; read of DATA has no side effects.
//  Async reset mid-transfer: all state to reset values immediately; partial byte discarded.
//  Offset decode uses cpu_ADDR[15:2]==BASE_ADDR[15:2]; writes outside window ignored.
// TESTING
//  Reset: assert reset mid-idle -> SD_CS_N all 1, SD_CLK=0, SD_CMD=1, sd_o@DATA=0xFF, busy=0.
//  Mode0 DIV=0, MISO model returns 0x3C, write DATA=0xA5 -> MOSI 1010_0101 on SCK rises, busy 16 clocks, DATA reads 0x3C.
//  Mode3 (CONF=0x30) DIV=3 -> SCK idles 1, half period 4 clocks, busy 64 clocks, byte exchanged correctly.
//  Write DATA=0x55 at busy cycle 5 -> ignored (MOSI pattern unchanged), STAT=0x03; after done write STAT -> STAT=0x00.
//  cpu_nWR held low 40 clocks on DATA, DIV=0 -> exactly one transfer, busy drops after 16 clocks, no retrigger.
//  NUM_CS=2: CONF=0x02 -> SD_CS_N=2'b01; async reset at transfer cycle 7 -> busy=0, SD_CS_N=2'b11 same cycle.

Source files
------------

// File: rtl/sd_spi_master.sv
// CPU-mapped SPI master: 4-byte register window (DATA/CONF/DIV/STAT), programmable
// SCK divider, CPOL/CPHA modes, up to four chip selects and a sticky overrun flag.
module sd_spi_master #(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter int          NUM_CS    = 1,
  parameter logic [7:0]  DIV_RESET = 8'd0
) (
  input  logic              c_sclk,
  input  logic              reset,
  input  logic [15:0]       cpu_ADDR,
  input  logic [7:0]        o_cpu_data,
  input  logic              cpu_nWR,
  output logic [7:0]        sd_o,
  output logic              sd_sel,
  output logic              busy,
  input  logic              SD_DAT,
  output logic              SD_CMD,
  output logic              SD_CLK,
  output logic [NUM_CS-1:0] SD_CS_N
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_next;
  logic              wr_prev;
  logic              write_acc, wr_data, wr_conf, wr_div, wr_stat, start;
  logic [1:0]        offset;
  logic [NUM_CS-1:0] cs_en;
  logic [3:0]        cs_rd;
  logic              cpol, cpha, ovr, sck;
  logic [7:0]        div, rx_reg, rx_shift, rx_next;
  logic [8:0]        tx_shift;
  logic [7:0]        half_cnt;
  logic [3:0]        phase_cnt;
  logic              phase_end, last_phase, done, leading, sample_now, shift_now;

  assign sd_sel    = (cpu_ADDR[15:2] == BASE_ADDR[15:2]);
  assign offset    = cpu_ADDR[1:0];
  assign write_acc = sd_sel && !cpu_nWR && wr_prev;
  assign wr_data   = write_acc && (offset == 2'd0);
  assign wr_conf   = write_acc && (offset == 2'd1);
  assign wr_div    = write_acc && (offset == 2'd2);
  assign wr_stat   = write_acc && (offset == 2'd3);
  assign start     = wr_data && (state == IDLE);

  // Even phases end on the leading SCK edge, odd phases on the trailing edge.
  assign phase_end  = (state == SHIFT) && (half_cnt == 8'd0);
  assign last_phase = (phase_cnt == 4'd15);
  assign done       = phase_end && last_phase;
  assign leading    = !phase_cnt[0];
  assign sample_now = phase_end && (leading != cpha);
  assign shift_now  = phase_end && (leading == cpha);
  assign rx_next    = {rx_shift[6:0], SD_DAT};

  always_ff @(posedge c_sclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == SHIFT);
    SD_CMD = (state == SHIFT) ? tx_shift[8] : 1'b1;
  end

  assign SD_CLK  = sck;
  assign SD_CS_N = ~cs_en;

  always_comb begin
    cs_rd = '0;
    cs_rd[NUM_CS-1:0] = cs_en;
    sd_o = 8'h00;
    if (sd_sel) begin
      case (offset)
        2'd0: sd_o = rx_reg;
        2'd1: sd_o = {2'b00, cpha, cpol, cs_rd};
        2'd2: sd_o = div;
        2'd3: sd_o = {6'b0, ovr, (state == SHIFT)};
        default: sd_o = 8'h00;
      endcase
    end
  end

  // The 9-bit tx register carries a filler bit so that CPHA=1 presents bit 7 only
  // after the first leading edge, while CPHA=0 presents it from the first cycle.
  always_ff @(posedge c_sclk or posedge reset) begin
    if (reset) begin
      wr_prev   <= 1'b1;
      rx_reg    <= 8'hFF;
      rx_shift  <= 8'h00;
      tx_shift  <= 9'h1FF;
      cs_en     <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      div       <= DIV_RESET;
      ovr       <= 1'b0;
      sck       <= 1'b0;
      half_cnt  <= 8'd0;
      phase_cnt <= 4'd0;
    end else begin
      wr_prev <= cpu_nWR;
      if (state == IDLE) begin
        sck <= cpol;
        if (wr_conf) begin
          cs_en <= o_cpu_data[NUM_CS-1:0];
          cpol  <= o_cpu_data[4];
          cpha  <= o_cpu_data[5];
        end
        if (wr_div) div <= o_cpu_data;
        if (start) begin
          tx_shift  <= cpha ? {1'b1, o_cpu_data} : {o_cpu_data, 1'b1};
          half_cnt  <= div;
          phase_cnt <= 4'd0;
        end
      end else begin
        if (wr_data || wr_conf || wr_div) ovr <= 1'b1;
        if (phase_end) begin
          half_cnt  <= div;
          phase_cnt <= phase_cnt + 4'd1;
          sck       <= done ? cpol : ~sck;
          if (sample_now) rx_shift <= rx_next;
          if (shift_now)  tx_shift <= {tx_shift[7:0], 1'b1};
          if (done)       rx_reg   <= sample_now ? rx_next : rx_shift;
        end else begin
          half_cnt <= half_cnt - 8'd1;
        end
      end
      if (wr_stat) ovr <= 1'b0;
    end
  end

endmodule
